// File: rtl/keypad_pkg.sv
// Shared constants for the matrix keypad scanner: key encoding and the row/col to code map.
package keypad_pkg;

    // {present, code}; present = 0 means no key in the scan.
    localparam logic [4:0] KEY_NONE = 5'b0_0000;

    localparam logic [3:0] KEY_CLEAR     = 4'hC;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;

    // Indexed by {row[1:0], col[1:0]}.
    localparam logic [3:0] KEY_MAP [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

endpackage

// File: rtl/keypad_debounce.sv
// Whole-scan debouncer: accepts a snapshot once it repeats DEBOUNCE_SCANS times and pulses on new keys.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       scan_done,
    input  logic [4:0] snapshot,
    output logic       accept,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

    logic [4:0]    prev_q, prev_d;
    logic [4:0]    deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q;

    always_comb begin
        prev_d = prev_q;
        deb_d  = deb_q;
        cnt_d  = cnt_q;
        code_d = code_q;
        accept = 1'b0;
        if (scan_done) begin
            prev_d = snapshot;
            if (snapshot == prev_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = CW'(1);
            end
            if (cnt_d == CNT_MAX && snapshot != deb_q) begin
                deb_d  = snapshot;
                accept = snapshot[4];
            end
        end
        if (accept) begin
            code_d = snapshot[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            prev_q  <= KEY_NONE;
            deb_q   <= KEY_NONE;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= accept;
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = deb_q[4];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with debounced key pulses and a 4-digit BCD entry register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 65536,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] entry_num
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [4:0]    snap_q, snap_d;
    logic [15:0]   entry_q, entry_d;
    logic [4:0]    col_hit, snap_scan;
    logic          sample, scan_done, accept;

    assign sample    = (div_q == DIV_MAX);
    assign scan_done = sample && (col_idx_q == 2'd3);

    // Walk rows high to low so the lowest pressed row wins within a column.
    always_comb begin
        col_hit = KEY_NONE;
        for (int r = 3; r >= 0; r--) begin
            if (!row_in[r]) begin
                col_hit = {1'b1, KEY_MAP[{r[1:0], col_idx_q}]};
            end
        end
    end

    // Column 0 starts a fresh scan; later columns only fill an empty snapshot.
    assign snap_scan = (col_idx_q == 2'd0 || !snap_q[4]) ? col_hit : snap_q;

    always_comb begin
        div_d     = sample ? '0 : div_q + 1'b1;
        col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
        snap_d    = sample ? snap_scan : snap_q;
        entry_d   = entry_q;
        if (accept) begin
            if (snap_scan[3:0] <= KEY_DIGIT_MAX) begin
                entry_d = {entry_q[11:0], snap_scan[3:0]};
            end else if (snap_scan[3:0] == KEY_CLEAR) begin
                entry_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            div_q     <= '0;
            col_idx_q <= '0;
            snap_q    <= KEY_NONE;
            entry_q   <= '0;
        end else begin
            div_q     <= div_d;
            col_idx_q <= col_idx_d;
            snap_q    <= snap_d;
            entry_q   <= entry_d;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk       (clk),
        .clr       (clr),
        .scan_done (scan_done),
        .snapshot  (snap_scan),
        .accept    (accept),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    assign col_out   = ~(4'b0001 << col_idx_q);
    assign entry_num = entry_q;

endmodule
